// File: rtl/crc8_frame_checker_if.sv
// Serial CRC-8 receive bus: framing/bit inputs toward the checker and
// reassembled bytes plus frame verdict back to the packet layer.
interface crc8_frame_checker_if;
  logic       start;
  logic       bit_in;
  logic       bit_en;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       busy;
  logic       done;
  logic       crc_ok;
  logic [7:0] crc_calc;
  logic [7:0] crc_rx;

  modport master (
    output start, bit_in, bit_en,
    input  byte_out, byte_valid, busy, done, crc_ok, crc_calc, crc_rx
  );

  modport slave (
    input  start, bit_in, bit_en,
    output byte_out, byte_valid, busy, done, crc_ok, crc_calc, crc_rx
  );
endinterface

// File: rtl/crc8_frame_checker.sv
// Bit-serial CRC-8 frame checker: reassembles MSG_BYTES payload bytes, runs the
// CRC over them, captures the trailing CRC byte and flags whether they agree.
module crc8_frame_checker #(
  parameter logic [7:0] POLY      = 8'h07,
  parameter logic [7:0] INIT      = 8'h00,
  parameter bit         REFLECT   = 1'b0,
  parameter logic [7:0] XOR_OUT   = 8'h00,
  parameter int         MSG_BYTES = 9
) (
  input logic                 clk,
  input logic                 rst,
  crc8_frame_checker_if.slave bus
);

  localparam logic [7:0] LAST_BYTE = 8'(MSG_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    CRCB    = 2'd2
  } state_t;

  state_t     state, state_n;
  logic [7:0] crc;
  logic [7:0] sh;
  logic [7:0] sh_n;
  logic [7:0] crc_final;
  logic [2:0] bit_cnt;
  logic [7:0] byte_cnt;
  logic       accept;
  logic       last_bit;
  logic       last_byte;

  function automatic logic [7:0] crc_step(input logic [7:0] c, input logic b);
    logic fb;
    fb = c[7] ^ b;
    return {c[6:0], 1'b0} ^ (fb ? POLY : 8'h00);
  endfunction

  function automatic logic [7:0] bitrev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  // start wins over a coincident bit, so that bit is never accepted
  always_comb begin
    accept    = bus.bit_en && !bus.start && (state != IDLE);
    last_bit  = (bit_cnt == 3'd7);
    last_byte = (byte_cnt == LAST_BYTE);
    sh_n      = REFLECT ? {bus.bit_in, sh[7:1]} : {sh[6:0], bus.bit_in};
    crc_final = (REFLECT ? bitrev8(crc) : crc) ^ XOR_OUT;
  end

  always_comb begin
    state_n = state;
    if (bus.start) begin
      state_n = PAYLOAD;
    end else begin
      case (state)
        PAYLOAD: if (accept && last_bit && last_byte) state_n = CRCB;
        CRCB:    if (accept && last_bit) state_n = IDLE;
        default: state_n = state;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc            <= INIT;
      sh             <= 8'h00;
      bit_cnt        <= 3'd0;
      byte_cnt       <= 8'd0;
      bus.byte_out   <= 8'h00;
      bus.byte_valid <= 1'b0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.crc_ok     <= 1'b0;
      bus.crc_calc   <= 8'h00;
      bus.crc_rx     <= 8'h00;
    end else begin
      bus.byte_valid <= 1'b0;
      bus.done       <= 1'b0;
      bus.busy       <= (state_n != IDLE);
      if (bus.start) begin
        crc        <= INIT;
        bit_cnt    <= 3'd0;
        byte_cnt   <= 8'd0;
        bus.crc_ok <= 1'b0;
      end else if (accept) begin
        sh      <= sh_n;
        bit_cnt <= bit_cnt + 3'd1;
        if (state == PAYLOAD) begin
          crc <= crc_step(crc, bus.bit_in);
          if (last_bit) begin
            bus.byte_out   <= sh_n;
            bus.byte_valid <= 1'b1;
            byte_cnt       <= last_byte ? 8'd0 : byte_cnt + 8'd1;
          end
        end else if (last_bit) begin
          // CRC register is frozen here; compare the received byte to it
          bus.crc_rx   <= sh_n;
          bus.crc_calc <= crc_final;
          bus.crc_ok   <= (sh_n == crc_final);
          bus.done     <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_crc8_frame_checker.sv
// Drives four checker instances (CRC-8, MAXIM, ROHC, ITU) with shared framing
// and per-instance bit streams, scoring them against a bytewise CRC model.
module tb_crc8_frame_checker;

  localparam int N = 4;
  localparam logic [7:0] P_POLY  [N] = '{8'h07, 8'h31, 8'h07, 8'h07};
  localparam logic [7:0] P_INIT  [N] = '{8'h00, 8'h00, 8'hFF, 8'h00};
  localparam bit         P_REFL  [N] = '{1'b0, 1'b1, 1'b1, 1'b0};
  localparam logic [7:0] P_XOR   [N] = '{8'h00, 8'h00, 8'h00, 8'h55};
  localparam logic [7:0] P_CHECK [N] = '{8'hF4, 8'hA1, 8'hD0, 8'hA1};

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         bit_en;
  logic [N-1:0] bit_in_v;

  logic [7:0]   byte_out_w [N];
  logic [7:0]   crc_calc_w [N];
  logic [7:0]   crc_rx_w   [N];
  logic [N-1:0] byte_valid_w, busy_w, done_w, crc_ok_w;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] frm      [N][10];
  logic [7:0] exp_calc [N];

  int         obs_n    [N];
  logic [7:0] obs_b    [N][256];
  int         done_n   [N];
  logic [7:0] got_calc [N];
  logic [7:0] got_rx   [N];
  logic       got_ok   [N];
  int         base_n   [N];
  int         base_d   [N];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    crc8_frame_checker_if bus ();
    assign bus.start        = start;
    assign bus.bit_en       = bit_en;
    assign bus.bit_in       = bit_in_v[g];
    assign byte_out_w[g]    = bus.byte_out;
    assign crc_calc_w[g]    = bus.crc_calc;
    assign crc_rx_w[g]      = bus.crc_rx;
    assign byte_valid_w[g]  = bus.byte_valid;
    assign busy_w[g]        = bus.busy;
    assign done_w[g]        = bus.done;
    assign crc_ok_w[g]      = bus.crc_ok;

    crc8_frame_checker #(
      .POLY(P_POLY[g]), .INIT(P_INIT[g]), .REFLECT(P_REFL[g]),
      .XOR_OUT(P_XOR[g]), .MSG_BYTES(9)
    ) dut (
      .clk(clk), .rst(rst), .bus(bus.slave)
    );
  end

  initial begin
    for (int d = 0; d < N; d++) begin
      obs_n[d]    = 0;
      done_n[d]   = 0;
      got_calc[d] = 8'h00;
      got_rx[d]   = 8'h00;
      got_ok[d]   = 1'b0;
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < N; d++) begin
      if (byte_valid_w[d]) begin
        obs_b[d][8'(obs_n[d])] = byte_out_w[d];
        obs_n[d]++;
      end
      if (done_w[d]) begin
        done_n[d]++;
        got_calc[d] = crc_calc_w[d];
        got_rx[d]   = crc_rx_w[d];
        got_ok[d]   = crc_ok_w[d];
      end
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  // Textbook bytewise CRC: left-shifting for plain, right-shifting with the
  // mirrored polynomial and mirrored init for reflected variants.
  function automatic logic [7:0] ref_crc(input int d);
    logic [7:0] c;
    if (!P_REFL[d]) begin
      c = P_INIT[d];
      for (int i = 0; i < 9; i++) begin
        c = c ^ frm[d][i];
        for (int b = 0; b < 8; b++) c = c[7] ? ((c << 1) ^ P_POLY[d]) : (c << 1);
      end
    end else begin
      c = rev8(P_INIT[d]);
      for (int i = 0; i < 9; i++) begin
        c = c ^ frm[d][i];
        for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ rev8(P_POLY[d])) : (c >> 1);
      end
    end
    return c ^ P_XOR[d];
  endfunction

  // mode 0: "123456789" good CRC, 1: same with bad CRC, 2: random good, 3: random CRC byte
  task automatic set_frame(input int mode);
    for (int d = 0; d < N; d++) begin
      for (int i = 0; i < 9; i++)
        frm[d][i] = (mode < 2) ? 8'h31 + 8'(i) : 8'($urandom);
      exp_calc[d] = (mode < 2) ? P_CHECK[d] : ref_crc(d);
      case (mode)
        1:       frm[d][9] = P_CHECK[d] ^ 8'h01;
        3:       frm[d][9] = ($urandom_range(1, 0) == 0) ? exp_calc[d] : 8'($urandom);
        default: frm[d][9] = exp_calc[d];
      endcase
    end
  endtask

  task automatic snapshot();
    for (int d = 0; d < N; d++) begin
      base_n[d] = obs_n[d];
      base_d[d] = done_n[d];
    end
  endtask

  task automatic idle_noise(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      bit_en   = 1'($urandom);
      bit_in_v = 4'($urandom);
    end
    @(posedge clk); #1;
    bit_en = 1'b0;
  endtask

  // the coincident bit_en must be discarded in favour of start
  task automatic pulse_start();
    @(posedge clk); #1;
    start    = 1'b1;
    bit_en   = 1'b1;
    bit_in_v = 4'($urandom);
    @(posedge clk); #1;
    start  = 1'b0;
    bit_en = 1'b0;
  endtask

  task automatic drive_bits(input int nbits, input int max_gap);
    for (int k = 0; k < nbits; k++) begin
      repeat ($urandom_range(max_gap, 0)) begin
        @(posedge clk); #1;
        bit_en   = 1'b0;
        bit_in_v = 4'($urandom);
      end
      @(posedge clk); #1;
      bit_en = 1'b1;
      for (int d = 0; d < N; d++)
        bit_in_v[d] = frm[d][k/8][P_REFL[d] ? (k % 8) : (7 - k % 8)];
    end
    @(posedge clk); #1;
    bit_en = 1'b0;
  endtask

  task automatic check_frame(input string name);
    for (int d = 0; d < N; d++) begin
      check_val($sformatf("%s[%0d] byte_count", name, d), 32'(obs_n[d] - base_n[d]), 32'd9);
      for (int i = 0; i < 9; i++)
        check_val($sformatf("%s[%0d] byte%0d", name, d, i),
                  32'(obs_b[d][8'(base_n[d] + i)]), 32'(frm[d][i]));
      check_val($sformatf("%s[%0d] done_count", name, d), 32'(done_n[d] - base_d[d]), 32'd1);
      check_val($sformatf("%s[%0d] crc_calc", name, d), 32'(got_calc[d]), 32'(exp_calc[d]));
      check_val($sformatf("%s[%0d] crc_rx", name, d), 32'(got_rx[d]), 32'(frm[d][9]));
      check_val($sformatf("%s[%0d] crc_ok", name, d), 32'(got_ok[d]),
                32'(frm[d][9] == exp_calc[d]));
      check_val($sformatf("%s[%0d] crc_ok_hold", name, d), 32'(crc_ok_w[d]),
                32'(frm[d][9] == exp_calc[d]));
      check_val($sformatf("%s[%0d] busy_after", name, d), 32'(busy_w[d]), 32'd0);
    end
  endtask

  task automatic run_frame(input string name, input int mode, input int max_gap, input int noise);
    set_frame(mode);
    snapshot();
    if (noise > 0) idle_noise(noise);
    pulse_start();
    drive_bits(80, max_gap);
    repeat (4) @(posedge clk);
    #1;
    if (noise > 0) idle_noise(noise);
    check_frame(name);
  endtask

  task automatic check_all_zero(input string name);
    for (int d = 0; d < N; d++) begin
      check_val($sformatf("%s[%0d] byte_out", name, d), 32'(byte_out_w[d]), 32'd0);
      check_val($sformatf("%s[%0d] byte_valid", name, d), 32'(byte_valid_w[d]), 32'd0);
      check_val($sformatf("%s[%0d] busy", name, d), 32'(busy_w[d]), 32'd0);
      check_val($sformatf("%s[%0d] done", name, d), 32'(done_w[d]), 32'd0);
      check_val($sformatf("%s[%0d] crc_ok", name, d), 32'(crc_ok_w[d]), 32'd0);
      check_val($sformatf("%s[%0d] crc_calc", name, d), 32'(crc_calc_w[d]), 32'd0);
      check_val($sformatf("%s[%0d] crc_rx", name, d), 32'(crc_rx_w[d]), 32'd0);
    end
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    bit_en   = 1'b0;
    bit_in_v = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    run_frame("check_good", 0, 0, 0);
    run_frame("check_bad", 1, 0, 0);
    run_frame("gaps_noise", 0, 5, 6);
    for (int r = 0; r < 6; r++)
      run_frame($sformatf("rand%0d", r), 2 + (r % 2), 3, 3);

    // restart after three payload bytes
    set_frame(2);
    snapshot();
    pulse_start();
    drive_bits(24, 1);
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < N; d++) begin
      check_val($sformatf("abort[%0d] byte_count", d), 32'(obs_n[d] - base_n[d]), 32'd3);
      for (int i = 0; i < 3; i++)
        check_val($sformatf("abort[%0d] byte%0d", d, i),
                  32'(obs_b[d][8'(base_n[d] + i)]), 32'(frm[d][i]));
      check_val($sformatf("abort[%0d] busy", d), 32'(busy_w[d]), 32'd1);
    end
    run_frame("after_abort", 2, 1, 0);
    for (int d = 0; d < N; d++)
      check_val($sformatf("abort[%0d] total_done", d), 32'(done_n[d] - base_d[d]), 32'd1);

    // asynchronous reset between clock edges mid-frame
    set_frame(2);
    pulse_start();
    drive_bits(30, 1);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    @(negedge clk);
    rst = 1'b0;
    run_frame("after_rst", 0, 2, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
